// File: rtl/uart_tx_if.sv
// Host-side handshake and line signals of the 8N1 UART transmitter.
interface uart_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       TX;
    logic       BUSY;
    logic       TX_DONE;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  TX,
        input  BUSY,
        input  TX_DONE
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output TX,
        output BUSY,
        output TX_DONE
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer; bit timing matches uart_rx.
module uart_tx #(
    parameter int unsigned BIT_LENGTH = 2604,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic CLK,
    input logic RESET,
    uart_tx_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [13:0] BitEnd   = 14'(BIT_LENGTH);
    localparam logic        StopLast = 1'(STOP_BITS - 1);

    state_e      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        stop_q, stop_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic bit_end, stop_end, load, accept;

    always_comb begin
        bit_end  = (cnt_q == BitEnd);
        stop_end = (state_q == StStop) && bit_end && (stop_q == StopLast);
        load     = buf_valid_q && ((state_q == StIdle) || stop_end);
        accept   = bus.TX_VALID && !buf_valid_q;

        state_d     = state_q;
        cnt_d       = (state_q == StIdle || bit_end) ? 14'd0 : cnt_q + 14'd1;
        idx_d       = idx_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        done_d      = stop_end;

        // accept and load are mutually exclusive: load needs buf_valid_q, accept needs !buf_valid_q
        if (accept) begin
            buf_d       = bus.TX_DATA;
            buf_valid_d = 1'b1;
        end else if (load) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StStart;
                    shift_d = buf_q;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (stop_end) begin
                    if (load) begin
                        state_d = StStart;
                        shift_d = buf_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so TX changes on the bit boundary edge
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[idx_d];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StIdle;
            cnt_q       <= 14'd0;
            idx_q       <= 3'd0;
            stop_q      <= 1'b0;
            shift_q     <= 8'd0;
            buf_q       <= 8'd0;
            buf_valid_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.TX_READY = ~buf_valid_q;
    assign bus.TX       = tx_q;
    assign bus.BUSY     = busy_q;
    assign bus.TX_DONE  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle comparison of {TX, TX_READY, BUSY, TX_DONE} against a frame-list model.
module tb_uart_tx;

    localparam int BL    = 15;
    localparam int SB    = 1;
    localparam int BITC  = BL + 1;
    localparam int FRAME = (9 + SB) * BITC;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_if bus ();

    uart_tx #(
        .BIT_LENGTH(BL),
        .STOP_BITS (SB)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    // Model: each accepted byte is a frame with accept cycle k and first start-bit cycle s.
    int         f_k[$];
    int         f_s[$];
    logic [7:0] f_b[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [3:0] exp_vec(input int c);
        logic tx, rdy, busy, done;
        tx = 1'b1; rdy = 1'b1; busy = 1'b0; done = 1'b0;
        for (int i = 0; i < f_s.size(); i++) begin
            int s;
            int idx;
            s = f_s[i];
            if (c >= s && c < s + FRAME) begin
                busy = 1'b1;
                idx  = (c - s) / BITC;
                if (idx == 0) tx = 1'b0;
                else if (idx <= 8) tx = f_b[i][idx-1];
            end
            if (c == s + FRAME) done = 1'b1;
            if (c > f_k[i] && c < s) rdy = 1'b0;
        end
        return {tx, rdy, busy, done};
    endfunction

    // Advance one clock: update the model at the edge, return at the following negedge.
    task automatic tick();
        int s;
        logic [3:0] e;
        e = exp_vec(cyc);
        @(posedge CLK);
        if (!RESET) begin
            f_k.delete(); f_s.delete(); f_b.delete();
        end else if (bus.TX_VALID && e[2]) begin
            s = cyc + 2;
            if (f_s.size() > 0 && f_s[$] + FRAME > s) s = f_s[$] + FRAME;
            f_k.push_back(cyc);
            f_s.push_back(s);
            f_b.push_back(bus.TX_DATA);
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        for (int i = 0; i < 103; i++) begin
            if (i == 3) RESET = 1'b1;
            tick();
            checks++;
            if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== exp_vec(cyc)) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc,
                         {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE}, exp_vec(cyc));
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        int k;
        int done_cyc;
        done_cyc = -1;
        k = cyc;
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = b;
        for (int i = 0; i < FRAME + 6; i++) begin
            tick();
            bus.TX_VALID = 1'b0;
            bus.TX_DATA  = 8'($urandom);
            if (bus.TX_DONE === 1'b1 && done_cyc < 0) done_cyc = cyc;
            checks++;
            if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== exp_vec(cyc)) begin
                errors++;
                $display("FAIL single_%02h cyc=%0d got=%b exp=%b", b, cyc,
                         {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE}, exp_vec(cyc));
            end
        end
        checks++;
        if (done_cyc !== k + 2 + FRAME) begin
            errors++;
            $display("FAIL single_done_%02h got=%0d exp=%0d", b, done_cyc, k + 2 + FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int d0;
        int d1;
        n0 = f_s.size();
        d0 = -1;
        d1 = -1;
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = 8'h00;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            tick();
            bus.TX_DATA = 8'hFF;
            if (f_s.size() >= n0 + 2) bus.TX_VALID = 1'b0;
            if (bus.TX_DONE === 1'b1) begin
                if (d0 < 0) d0 = cyc;
                else if (d1 < 0) d1 = cyc;
            end
            checks++;
            if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== exp_vec(cyc)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc,
                         {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE}, exp_vec(cyc));
            end
        end
        bus.TX_VALID = 1'b0;
        checks++;
        if (d0 < 0 || d1 - d0 !== FRAME) begin
            errors++;
            $display("FAIL b2b_done_spacing got=%0d exp=%0d", d1 - d0, FRAME);
        end
    endtask

    task automatic test_hold_valid();
        int hs;
        hs = 0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            bus.TX_VALID = (i < 150);
            bus.TX_DATA  = 8'($urandom);
            if (bus.TX_VALID && bus.TX_READY === 1'b1) hs++;
            tick();
            checks++;
            if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== exp_vec(cyc)) begin
                errors++;
                $display("FAIL hold_valid cyc=%0d got=%b exp=%b", cyc,
                         {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE}, exp_vec(cyc));
            end
        end
        bus.TX_VALID = 1'b0;
        checks++;
        if (hs !== 2) begin
            errors++;
            $display("FAIL hold_valid_accepts got=%0d exp=2", hs);
        end
    endtask

    task automatic test_reset_mid();
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = 8'h3C;
        for (int i = 0; i < 2 + 3 * BITC + 5; i++) begin
            tick();
            bus.TX_VALID = 1'b0;
        end
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        checks++;
        if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=1100",
                     {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE});
        end
        for (int i = 0; i < 5; i++) tick();
        test_single(8'h81);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            bus.TX_VALID = (i < 5 * FRAME) && ($urandom_range(0, 7) == 0);
            bus.TX_DATA  = 8'($urandom);
            tick();
            checks++;
            if ({bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE} !== exp_vec(cyc)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                         {bus.TX, bus.TX_READY, bus.BUSY, bus.TX_DONE}, exp_vec(cyc));
            end
        end
        bus.TX_VALID = 1'b0;
    endtask

    initial begin
        bus.TX_VALID = 1'b0;
        bus.TX_DATA  = 8'h00;
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_back_to_back();
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. It is the transmit-side companion of the team's uart_rx and runs on the same clock.
- Bit timing is identical to uart_rx, so a loopback from TX to the receiver's RX recovers every byte.
- Bytes arrive through a valid/ready handshake into a one-entry holding buffer, which allows back-to-back frames with no idle gap.
- TX_DONE is a one-cycle pulse that tells the host each frame has completed.

Parameters:
- BIT_LENGTH, 2604: terminal count of the bit-period counter. One bit lasts BIT_LENGTH+1 clock cycles, the same as uart_rx.
- STOP_BITS, 1: number of stop bits. Legal values are 1 and 2.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  synchronous, active-low reset. RESET==0 at a rising CLK edge resets the block.
- TX_DATA  input  8  byte to send, LSB first.
- TX_VALID  input  1  host presents TX_DATA this cycle.
- TX_READY  output  1  holding buffer is empty; a byte is accepted when TX_VALID & TX_READY.
- TX  output  1  serial line; idles high.
- BUSY  output  1  a frame is on the line (state is not IDLE).
- TX_DONE  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset values (RESET==0):
  - TX=1, TX_READY=1, BUSY=0, TX_DONE=0.
  - Holding buffer is emptied, state=IDLE, bit counter=0, bit index=0.
  - A frame in progress is aborted immediately; TX is high from the next edge.
- TX, BUSY and TX_DONE are registered outputs. TX_READY is the inverse of the registered buffer-valid flag.
- Accept: on a cycle where TX_VALID=1 and TX_READY=1, TX_DATA is captured into the buffer and TX_READY is 0 from the next cycle. TX_VALID while TX_READY=0 is ignored and the data is not captured.
- Buffer load into the shifter: at a load the buffer empties and TX_READY returns to 1 on the following cycle. A load happens when the buffer is valid and either:
  - state is IDLE, or
  - the final stop-bit period ends.
- The shifter has four states:
  - IDLE: TX=1. On a load, go to START_BIT, counter=0.
  - START_BIT: TX=0 for BIT_LENGTH+1 cycles, then go to DATA_BIT with index=0.
  - DATA_BIT: TX=shift[index] for BIT_LENGTH+1 cycles per bit. After index 7, go to STOP_BIT.
  - STOP_BIT: TX=1 for STOP_BITS*(BIT_LENGTH+1) cycles. At the end, pulse TX_DONE and go to START_BIT if a load occurs, otherwise to IDLE.
- Counter: counts 0..BIT_LENGTH and wraps to 0 at each bit boundary. The counter is 14 bits wide, so BIT_LENGTH must be at most 16383.
- Latency: a byte accepted in cycle k while IDLE with the buffer empty drives TX low from cycle k+2.
- Frame length: (9+STOP_BITS)*(BIT_LENGTH+1) cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: when the buffer is full at the end of the stop bit, the next start bit begins on the next cycle. There is no extra idle cycle, and TX_DONE pulses in that same cycle.
- BUSY is 1 from the first start-bit cycle through the last stop-bit cycle. It stays 1 across back-to-back frames.
- Accept and load in the same cycle cannot occur, because a load requires buffer-valid and that forces TX_READY=0.
- RESET has priority over every event, including an accept in the same cycle.
- TX_DATA changing after acceptance has no effect on the frame.

Test Plan:
1. BIT_LENGTH=15 (16 cycles/bit). RESET low for 3 cycles, then high -> TX=1, TX_READY=1, BUSY=0, TX_DONE=0; no transitions on TX for 100 cycles.
2. Send 0xA5 at cycle k -> TX low during k+2..k+17. Data bits 1,0,1,0,0,1,0,1 follow at 16 cycles each, then a stop bit high for 16 cycles. TX_DONE pulses once, 160 cycles after k+2; BUSY falls at the same cycle.
3. Send 0x00 and then 0xFF, with 0xFF presented as soon as TX_READY rises -> the 0xFF start bit immediately follows the 0x00 stop bit with no gap. There are two TX_DONE pulses 160 cycles apart, and BUSY stays high across the boundary.
4. Present TX_VALID continuously while the buffer is full -> exactly 2 bytes are accepted (one in the shifter, one in the buffer). TX_READY stays 0 until the first frame's stop bit ends.
5. Assert RESET low mid-DATA_BIT of 0x3C -> TX=1, BUSY=0, TX_READY=1 on the next edge. A subsequent send of 0x81 is transmitted correctly and no stale bits appear.
6. Loopback TX to uart_rx (both at default BIT_LENGTH=2604, STOP_BITS=1) and send 0x55, 0x0F, 0xC3 -> uart_rx RX_DONE pulses 3 times, with RX_DATA equal to each byte in order.
